// File: rtl/risc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// risc_ctrl_pkg
// Shared definitions for the 16-bit RISC multi-cycle controller:
//   - opcode values (instr[15:12])
//   - ALU operation codes driven on alu_op
//   - controller state encoding and decoded instruction classes
//   - err_code values
//   - rtype_alu(): maps an R-type opcode onto its ALU operation
// ---------------------------------------------------------------------------
package risc_ctrl_pkg;

  // Opcodes
  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_INV = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_SLT = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INV = 3'b010;
  localparam logic [2:0] ALU_LSL = 3'b011;
  localparam logic [2:0] ALU_LSR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_LD, CLS_ST, CLS_RTYPE, CLS_BEQ, CLS_BNE, CLS_JMP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  // R-type opcodes 2..9 map in order onto ALU codes ADD..SLT.
  function automatic logic [2:0] rtype_alu(input logic [3:0] op);
    logic [3:0] diff;
    diff = op - OP_ADD;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/risc_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// risc_multicycle_ctrl_if
// Bundle between the multi-cycle controller and the datapath / data memory.
//   master : controller side (drives strobes, status)
//   slave  : datapath side  (drives run, opcode, mem_ack)
// Inputs to controller : run, opcode[3:0], mem_ack, step (RISC_CTRL_STEP_EN)
// Outputs              : ir_load_en, pc_write_en, jump, beq, bne,
//                        mem_read_en, mem_write_en, alu_src, reg_dst,
//                        mem_to_reg, reg_write_en, alu_op[2:0],
//                        busy, halted, err, err_code[1:0]
// Optional macro: RISC_CTRL_STEP_EN adds the single-step input.
// ---------------------------------------------------------------------------
interface risc_multicycle_ctrl_if;
  logic       run;
  logic [3:0] opcode;
  logic       mem_ack;
`ifdef RISC_CTRL_STEP_EN
  logic       step;
`endif
  logic       ir_load_en;
  logic       pc_write_en;
  logic       jump;
  logic       beq;
  logic       bne;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       alu_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write_en;
  logic [2:0] alu_op;
  logic       busy;
  logic       halted;
  logic       err;
  logic [1:0] err_code;

  modport master (
`ifdef RISC_CTRL_STEP_EN
    input  step,
`endif
    input  run, opcode, mem_ack,
    output ir_load_en, pc_write_en, jump, beq, bne, mem_read_en, mem_write_en,
           alu_src, reg_dst, mem_to_reg, reg_write_en, alu_op,
           busy, halted, err, err_code
  );

  modport slave (
`ifdef RISC_CTRL_STEP_EN
    output step,
`endif
    output run, opcode, mem_ack,
    input  ir_load_en, pc_write_en, jump, beq, bne, mem_read_en, mem_write_en,
           alu_src, reg_dst, mem_to_reg, reg_write_en, alu_op,
           busy, halted, err, err_code
  );
endinterface

// File: rtl/risc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// risc_ctrl_decode
// Purely combinational opcode decoder.
//   opcode_i  : instr[15:12]
//   cls_o     : instruction class (LD/ST/RTYPE/BEQ/BNE/JMP/HALT/ILLEGAL)
//   alu_op_o  : ALU operation for the EXEC phase
//   reg_dst_o : 1 = R-type destination field
//   alu_src_o : 1 = immediate operand (LD/ST address)
// ---------------------------------------------------------------------------
module risc_ctrl_decode
  import risc_ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic [3:0] opcode_i,
  output op_class_t  cls_o,
  output logic [2:0] alu_op_o,
  output logic       reg_dst_o,
  output logic       alu_src_o
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    cls_o     = CLS_ILLEGAL;
    alu_op_o  = ALU_ADD;
    reg_dst_o = 1'b0;
    alu_src_o = 1'b0;
    // The halt opcode is checked first so it overrides any other meaning.
    if (opcode_i == HALT_OPCODE) begin
      cls_o = CLS_HALT;
    end else begin
      case (opcode_i)
        OP_LD: begin cls_o = CLS_LD; alu_src_o = 1'b1; end
        OP_ST: begin cls_o = CLS_ST; alu_src_o = 1'b1; end
        OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: begin
          cls_o     = CLS_RTYPE;
          reg_dst_o = 1'b1;
          alu_op_o  = rtype_alu(opcode_i);
        end
        OP_BEQ:  begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; end
        OP_BNE:  begin cls_o = CLS_BNE; alu_op_o = ALU_SUB; end
        OP_JMP:  cls_o = CLS_JMP;
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/risc_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// risc_multicycle_ctrl
// Multi-cycle control FSM for the 16-bit RISC datapath:
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> boundary
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : risc_multicycle_ctrl_if.master (strobes, handshake, status)
// Parameters:
//   MEM_TIMEOUT : MEM cycles without mem_ack before a timeout error (1..255)
//   HALT_OPCODE : opcode that halts the core
// Optional macro RISC_CTRL_STEP_EN: in IDLE with run=0, a rising step
// starts one instruction; holding step high does not run a second one.
// Control outputs are combinational from state + opcode (+ mem_ack for the
// store commit), so an asynchronous reset drops them immediately.
// ---------------------------------------------------------------------------
module risc_multicycle_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input logic                   clk,
  input logic                   rst_n,
  risc_multicycle_ctrl_if.master bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  err_code_t  err_code_q, err_code_d;

  op_class_t  cls;
  logic [2:0] dec_alu_op;
  logic       dec_reg_dst;
  logic       dec_alu_src;
  state_t     boundary;

  risc_ctrl_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
    .opcode_i (bus.opcode),
    .cls_o    (cls),
    .alu_op_o (dec_alu_op),
    .reg_dst_o(dec_reg_dst),
    .alu_src_o(dec_alu_src)
  );

  assign boundary = bus.run ? ST_FETCH : ST_IDLE;

`ifdef RISC_CTRL_STEP_EN
  logic step_prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_prev_q <= 1'b0;
    else        step_prev_q <= bus.step;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic. The wait counter only counts inside MEM and restarts
  // from zero on every entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
`ifdef RISC_CTRL_STEP_EN
        else if (bus.step && !step_prev_q) state_d = ST_FETCH;
`endif
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (cls)
          CLS_ILLEGAL: begin state_d = ST_ERROR; err_code_d = ERR_ILLEGAL; end
          CLS_HALT:    state_d = ST_HALTED;
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls)
          CLS_LD, CLS_ST: state_d = ST_MEM;
          CLS_RTYPE:      state_d = ST_WB;
          default:        state_d = boundary;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_d = (cls == CLS_LD) ? ST_WB : boundary;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WB:   state_d = boundary;
      default: state_d = state_q;  // HALTED / ERROR are terminal
    endcase
  end

  // Output logic
  always_comb begin
    bus.ir_load_en   = 1'b0;
    bus.pc_write_en  = 1'b0;
    bus.jump         = 1'b0;
    bus.beq          = 1'b0;
    bus.bne          = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.alu_src      = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.alu_op       = ALU_ADD;
    case (state_q)
      ST_FETCH: bus.ir_load_en = 1'b1;
      ST_EXEC: begin
        bus.alu_op  = dec_alu_op;
        bus.alu_src = dec_alu_src;
        bus.beq     = (cls == CLS_BEQ);
        bus.bne     = (cls == CLS_BNE);
        bus.jump    = (cls == CLS_JMP);
        bus.pc_write_en = (cls == CLS_BEQ) || (cls == CLS_BNE) || (cls == CLS_JMP);
      end
      ST_MEM: begin
        bus.alu_op       = ALU_ADD;
        bus.alu_src      = 1'b1;
        bus.mem_read_en  = (cls == CLS_LD);
        bus.mem_write_en = (cls == CLS_ST);
        bus.pc_write_en  = (cls == CLS_ST) && bus.mem_ack;
      end
      ST_WB: begin
        bus.reg_write_en = 1'b1;
        bus.pc_write_en  = 1'b1;
        bus.reg_dst      = dec_reg_dst;
        bus.mem_to_reg   = (cls == CLS_LD);
      end
      default: ;
    endcase
  end

  assign bus.busy     = !(state_q inside {ST_IDLE, ST_HALTED, ST_ERROR});
  assign bus.halted   = (state_q == ST_HALTED);
  assign bus.err      = (state_q == ST_ERROR);
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_risc_multicycle_ctrl
// Directed, table-driven bench for risc_multicycle_ctrl. Inputs change and
// outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_risc_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  risc_multicycle_ctrl_if bus ();

  risc_multicycle_ctrl #(.MEM_TIMEOUT(15), .HALT_OPCODE(4'hF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] opcode;
    int         waits;
    int         lat;
    int         rd;
    int         wr;
    int         rw;
    logic [2:0] alu;
    logic       beq;
    logic       bne;
    logic       jmp;
    logic       reg_dst;
    logic       m2r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {bus.ir_load_en, bus.pc_write_en, bus.jump, bus.beq, bus.bne,
            bus.mem_read_en, bus.mem_write_en, bus.alu_src, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write_en, bus.alu_op, bus.busy,
            bus.halted, bus.err, bus.err_code};
  endfunction

  function automatic logic [10:0] strobes();
    return {bus.ir_load_en, bus.pc_write_en, bus.jump, bus.beq, bus.bne,
            bus.mem_read_en, bus.mem_write_en, bus.alu_src, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write_en};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise run until the FETCH cycle is seen; returns 1 if seen.
  task automatic start_fetch(output bit seen);
    seen = 0;
    bus.run = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.ir_load_en) seen = 1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, commit, rd, wr, rw, il, mem_cyc;
    logic [2:0] exec_alu;
    logic c_beq, c_bne, c_jmp, c_rd, c_m2r;
    bit   seen;
    bus.opcode = v.opcode;
    start_fetch(seen);
    check($sformatf("v%0d fetch seen", idx), 32'(seen), 32'd1);
    cyc = 1; commit = 0; rd = 0; wr = 0; rw = 0; il = 1; mem_cyc = 0;
    exec_alu = 3'bxxx;
    {c_beq, c_bne, c_jmp, c_rd, c_m2r} = '0;
    while (commit == 0 && cyc < 40) begin
      cyc++;
      @(negedge clk);
      bus.mem_ack = (bus.mem_read_en || bus.mem_write_en) && (mem_cyc == v.waits);
      #1;
      if (bus.mem_read_en)  begin rd++; mem_cyc++; end
      if (bus.mem_write_en) begin wr++; mem_cyc++; end
      if (bus.ir_load_en) il++;
      if (bus.reg_write_en) rw++;
      if (cyc == 3) begin
        exec_alu = bus.alu_op;
        bus.run  = 1'b0;  // drop run mid-instruction; it must still finish
      end
      if (bus.pc_write_en) begin
        commit = cyc;
        {c_beq, c_bne, c_jmp, c_rd, c_m2r} =
          {bus.beq, bus.bne, bus.jump, bus.reg_dst, bus.mem_to_reg};
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check($sformatf("v%0d latency", idx),    32'(commit), 32'(v.lat));
    check($sformatf("v%0d rd cycles", idx),  32'(rd),     32'(v.rd));
    check($sformatf("v%0d wr cycles", idx),  32'(wr),     32'(v.wr));
    check($sformatf("v%0d regwr", idx),      32'(rw),     32'(v.rw));
    check($sformatf("v%0d irload", idx),     32'(il),     32'd1);
    check($sformatf("v%0d exec alu", idx),   32'(exec_alu), 32'(v.alu));
    check($sformatf("v%0d branch", idx),     32'({c_beq, c_bne, c_jmp}),
                                              32'({v.beq, v.bne, v.jmp}));
    check($sformatf("v%0d reg_dst", idx),    32'(c_rd),   32'(v.reg_dst));
    check($sformatf("v%0d mem_to_reg", idx), 32'(c_m2r),  32'(v.m2r));
    check($sformatf("v%0d idle after", idx), 32'({bus.busy, bus.ir_load_en}), 32'd0);
  endtask

  initial begin
    int   cnt;
    bit   seen;

    // opcode waits lat rd wr rw alu beq bne jmp reg_dst m2r
    vecs[0] = '{4'h2, 0, 4, 0, 0, 1, 3'b000, 0, 0, 0, 1, 0};  // ADD
    vecs[1] = '{4'h3, 0, 4, 0, 0, 1, 3'b001, 0, 0, 0, 1, 0};  // SUB
    vecs[2] = '{4'h9, 0, 4, 0, 0, 1, 3'b111, 0, 0, 0, 1, 0};  // SLT
    vecs[3] = '{4'h5, 0, 4, 0, 0, 1, 3'b011, 0, 0, 0, 1, 0};  // LSL
    vecs[4] = '{4'h0, 2, 7, 3, 0, 1, 3'b000, 0, 0, 0, 0, 1};  // LD, 2 waits
    vecs[5] = '{4'h0, 0, 5, 1, 0, 1, 3'b000, 0, 0, 0, 0, 1};  // LD, no wait
    vecs[6] = '{4'h1, 0, 4, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0};  // ST, no wait
    vecs[7] = '{4'h1, 3, 7, 0, 4, 0, 3'b000, 0, 0, 0, 0, 0};  // ST, 3 waits
    vecs[8] = '{4'hC, 0, 3, 0, 0, 0, 3'b001, 0, 1, 0, 0, 0};  // BNE
    vecs[9] = '{4'hD, 0, 3, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0};  // JMP

    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = 4'h0;
    bus.mem_ack = 1'b0;
`ifdef RISC_CTRL_STEP_EN
    bus.step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    // mem_ack while idle must not start anything
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("ack in idle", 32'(outs()), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back ADDs with run held: next FETCH right after WB.
    bus.opcode = 4'h2;
    start_fetch(seen);
    check("b2b fetch seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("b2b wb", 32'({bus.reg_write_en, bus.pc_write_en}), 32'b11);
    @(negedge clk);
    #1;
    check("b2b refetch", 32'(bus.ir_load_en), 32'd1);
    bus.run = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin @(negedge clk); #1; cnt++; end
    check("b2b back idle", 32'(bus.busy), 32'd0);

    // LD with no ack: 15 MEM cycles, then timeout error.
    bus.opcode = 4'h0;
    start_fetch(seen);
    bus.run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && !bus.err; i++) begin
      @(negedge clk);
      #1;
      if (bus.mem_read_en) cnt++;
    end
    check("timeout rd cycles", 32'(cnt), 32'd15);
    check("timeout err", 32'({bus.err, bus.err_code}), 32'b110);
    check("timeout strobes", 32'({strobes(), bus.busy}), 32'd0);
    bus.run = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("timeout sticky", 32'({bus.err, bus.err_code, bus.ir_load_en}), 32'b1100);
    do_reset();
    #1;
    check("timeout reset clears", 32'(outs()), 32'd0);

    // Illegal opcode A: error after DECODE, terminal.
    bus.opcode = 4'hA;
    start_fetch(seen);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("illegal err", 32'({bus.err, bus.err_code, bus.busy}), 32'b1010);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; cnt += int'(bus.ir_load_en); end
    check("illegal no fetch", 32'(cnt), 32'd0);
    do_reset();

    // HALT (F): halted, no further fetches with run held.
    bus.opcode = 4'hF;
    start_fetch(seen);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("halt status", 32'({bus.halted, bus.err, bus.busy}), 32'b100);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; cnt += int'(bus.ir_load_en); end
    check("halt no fetch", 32'(cnt), 32'd0);
    do_reset();

    // Reset asserted mid-MEM: strobes drop without waiting for a clock.
    bus.opcode = 4'h0;
    start_fetch(seen);
    bus.run = 1'b0;
    cnt = 0;
    while (!bus.mem_read_en && cnt < 10) begin @(negedge clk); #1; cnt++; end
    check("mid-mem reached", 32'(bus.mem_read_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-mem reset", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RISC_CTRL_STEP_EN
    // Step held high: exactly one instruction, then IDLE.
    bus.opcode = 4'h2;
    @(negedge clk);
    bus.step = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); #1; cnt += int'(bus.ir_load_en); end
    check("step one instr", 32'(cnt), 32'd1);
    check("step idle", 32'(bus.busy), 32'd0);
    bus.step = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/risc_multicycle_ctrl.md
Name: risc_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the 16-bit RISC datapath through its instruction phases (FETCH, DECODE, EXEC, MEM, WB).
- Drives all datapath control strobes, plus IR-load and PC-write enables.
- Waits on a data-memory acknowledge handshake.
- Reports halt/error status.
- Sits beside the datapath; its only datapath input is the 4-bit opcode.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM without mem_ack before error (1..255)
HALT_OPCODE, 4'hF, opcode that stops the core

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = fetch new instructions, 0 = stop at next instruction boundary
opcode  in  4  instr[15:12] from datapath IR
mem_ack  in  1  data memory done (read data valid / write accepted)
ir_load_en  out  1  load IR with instruction at PC
pc_write_en  out  1  commit pc_next into PC
jump, beq, bne  out  1 each  PC mux selects
mem_read_en, mem_write_en  out  1 each  data memory request, held until ack
alu_src, reg_dst, mem_to_reg, reg_write_en  out  1 each  datapath muxes / RF write
alu_op  out  3  ADD=000 SUB=001 INV=010 LSL=011 LSR=100 AND=101 OR=110 SLT=111
busy  out  1  state not IDLE/HALTED/ERROR
halted  out  1  HALT_OPCODE executed (sticky)
err  out  1  sticky: illegal opcode or memory timeout
err_code  out  2  00 none, 01 illegal opcode, 10 mem timeout

Behaviour:
- Opcodes:
  - 0 LD, 1 ST: alu ADD, alu_src=1.
  - 2 ADD, 3 SUB, 4 INV, 5 LSL, 6 LSR, 7 AND, 8 OR, 9 SLT: reg_dst=1, alu_src=0.
  - B BEQ, C BNE: alu SUB.
  - D JMP.
  - HALT_OPCODE: halt.
  - A and E (and F if not HALT_OPCODE): illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- Reset: state=IDLE; all outputs 0; wait counter 0; err_code 00.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: ir_load_en=1 for 1 cycle -> DECODE.
- DECODE:
  - illegal -> ERROR (err_code 01).
  - HALT -> HALTED.
  - otherwise -> EXEC.
- EXEC: drives alu_op/alu_src.
  - Branch/jump: beq|bne|jump asserted with pc_write_en=1 this cycle, then boundary.
  - LD/ST -> MEM.
  - R-type -> WB.
- MEM:
  - mem_read_en (LD) or mem_write_en (ST) held with alu_op=ADD, alu_src=1 every cycle until mem_ack.
  - mem_ack in the first MEM cycle means zero wait.
  - On ack: LD -> WB; ST asserts pc_write_en in the ack cycle, then boundary.
  - Counter reaches MEM_TIMEOUT with no ack -> ERROR (err_code 10), strobes drop.
- WB: reg_write_en=1, pc_write_en=1, one cycle.
  - LD: mem_to_reg=1, reg_dst=0.
  - R-type: reg_dst=1.
- Boundary: run=1 -> FETCH, else IDLE. run drop mid-instruction never aborts the instruction.
- Latency, cycles FETCH to PC commit:
  - branch/jump: 3
  - ST: 4+waits
  - R-type: 4
  - LD: 5+waits
- Control outputs are combinational from registered state + opcode. Opcode is stable from DECODE to boundary because IR loads only in FETCH.
- mem_ack outside MEM is ignored.
- HALTED and ERROR are terminal until rst_n. err_code holds the first error only.
- Reset asserted mid-MEM: all strobes drop asynchronously; the access is abandoned.

Optional Feature:
- RISC_CTRL_STEP_EN defined:
  - Adds input step (1 bit).
  - In IDLE with run=0, a step=1 cycle starts exactly one instruction, then returns to IDLE regardless of step level.
  - step is ignored while busy or when run=1.
- Undefined: no step port; IDLE leaves only on run.

Decomposition:
- Package risc_ctrl_pkg:
  - opcode localparams
  - alu_op codes
  - state encoding
  - err_code values
- Sub-module risc_ctrl_decode (combinational): opcode -> class {LD, ST, RTYPE, BEQ, BNE, JMP, HALT, ILLEGAL}, plus alu_op, reg_dst, alu_src.

Test Plan:
- ADD (opcode 2), run=1, no waits -> ir_load_en cycle 1; reg_write_en=1, reg_dst=1, pc_write_en=1 in cycle 4; alu_op=000; next cycle FETCH.
- LD (opcode 0), mem_ack after 2 wait cycles -> mem_read_en high 3 cycles; WB with mem_to_reg=1, reg_dst=0; pc_write_en at cycle 7.
- ST (opcode 1), mem_ack in first MEM cycle -> mem_write_en 1 cycle, pc_write_en same cycle, reg_write_en never 1.
- BNE (opcode C) -> bne=1, alu_op=001, pc_write_en=1 in cycle 3; no MEM/WB.
- LD with mem_ack never -> after 15 MEM cycles err=1, err_code=10, all strobes 0, busy=0; rst_n low clears.
- Opcode A -> err_code=01 after DECODE. Opcode F -> halted=1, no further ir_load_en. run dropped during EXEC of ADD -> instruction completes, then IDLE.
